// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a shared bitwise logic unit.
// The result sits in a single-entry valid/ready output register.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [1:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [1:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             can_accept;
    logic             gnt0, gnt1, gnt_any;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, result;

    // The register can take a new result when empty or when being drained now.
    assign can_accept = (state_q == EMPTY) || rsp_ready_i;

    // Round-robin grant: on contention, the requester not granted last time wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i && can_accept) begin
            if (req0_valid_i && req1_valid_i) begin
                if (last_grant_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0_valid_i) begin
                gnt0 = 1'b1;
            end else if (req1_valid_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign gnt_any = gnt0 || gnt1;

    // Operand mux follows the grant; requester 0 is the idle default.
    always_comb begin
        sel_op = req0_op_i;
        sel_a  = req0_a_i;
        sel_b  = req0_b_i;
        if (gnt1) begin
            sel_op = req1_op_i;
            sel_a  = req1_a_i;
            sel_b  = req1_b_i;
        end
    end

    always_comb begin
        result = '0;
        case (op_e'(sel_op))
            OP_AND:  result = sel_a & sel_b;
            OP_OR:   result = sel_a | sel_b;
            OP_XOR:  result = sel_a ^ sel_b;
            OP_ANDN: result = sel_a & ~sel_b;
            default: result = '0;
        endcase
    end

    // Next-state: a grant always (re)fills; a drain with no grant empties.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        data_d       = data_q;
        if (gnt_any) begin
            state_d      = FULL;
            last_grant_d = gnt1;
            id_d         = gnt1;
            data_d       = result;
        end else if ((state_q == FULL) && rsp_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            data_q       <= data_d;
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign rsp_valid_o  = (state_q == FULL);
    assign rsp_id_o     = id_q;
    assign rsp_data_o   = data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a reference model and result scoreboard.
module tb_logic_unit_arbiter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         v0, v1, rdy0, rdy1, rsp_valid, rsp_ready, rsp_id;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1, rsp_data;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t         sb[$];
    logic         m_full;
    logic         m_last;
    logic         m_id;
    logic [W-1:0] m_data;
    logic [W-1:0] saved;

    logic [W-1:0] tp_res [4];

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (v0),
        .req0_ready_o (rdy0),
        .req0_op_i    (op0),
        .req0_a_i     (a0),
        .req0_b_i     (b0),
        .req1_valid_i (v1),
        .req1_ready_o (rdy1),
        .req1_op_i    (op1),
        .req1_a_i     (a1),
        .req1_b_i     (b1),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance the model at posedge.
    task automatic step();
        logic   g0, g1, can;
        rsp_t   e;
        @(negedge clk);
        g0  = 1'b0;
        g1  = 1'b0;
        can = !m_full || rsp_ready;
        if (!rst && can) begin
            if (v0 && v1) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = v0;
                g1 = !v0 && v1;
            end
        end
        chk("req0_ready", W'(rdy0), W'(g0));
        chk("req1_ready", W'(rdy1), W'(g1));
        chk("rsp_valid", W'(rsp_valid), W'(m_full));
        if (m_full && sb.size() > 0) begin
            e = sb[0];
            chk("rsp_id_sb", W'(rsp_id), W'(e.id));
            chk("rsp_data_sb", rsp_data, e.data);
        end else begin
            chk("rsp_id_hold", W'(rsp_id), W'(m_id));
            chk("rsp_data_hold", rsp_data, m_data);
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_full = 1'b0;
            m_last = 1'b1;
            m_id   = 1'b0;
            m_data = '0;
        end else begin
            if (m_full && rsp_ready && sb.size() > 0) void'(sb.pop_front());
            if (g0 || g1) begin
                e.id   = g1;
                e.data = g1 ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
                sb.push_back(e);
                m_full = 1'b1;
                m_last = g1;
                m_id   = g1;
                m_data = e.data;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        tp_res[0] = 32'h05050505;
        tp_res[1] = 32'hAFAFAFAF;
        tp_res[2] = 32'hAAAAAAAA;
        tp_res[3] = 32'hA0A0A0A0;
        m_full = 1'b0; m_last = 1'b1; m_id = 1'b0; m_data = '0;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        op0 = 2'b00; op1 = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Reset, then a single request from requester 0.
        step(); step();
        rst = 1'b0;
        chk("reset_valid", W'(rsp_valid), '0);
        chk("reset_data", rsp_data, '0);
        v0 = 1'b1; op0 = 2'b00; a0 = 32'hFFFF0000; b0 = 32'h0F0F0F0F;
        step();
        v0 = 1'b0;
        chk("single_data", rsp_data, 32'h0F0F0000);
        chk("single_id", W'(rsp_id), '0);

        // Every opcode on requester 1, back to back.
        v1 = 1'b1; a1 = 32'hA5A5A5A5; b1 = 32'h0F0F0F0F;
        for (int k = 0; k < 4; k++) begin
            op1 = 2'(k);
            step();
            chk("op_valid", W'(rsp_valid), 1);
            chk("op_data", rsp_data, tp_res[k]);
            chk("op_id", W'(rsp_id), 1);
        end
        v1 = 1'b0;
        step();

        // Fresh reset, then continuous contention.
        rst = 1'b1; step(); rst = 1'b0;
        v0 = 1'b1; op0 = 2'b01; a0 = 32'h12340000; b0 = 32'h00005678;
        v1 = 1'b1; op1 = 2'b10; a1 = 32'hFFFFFFFF; b1 = 32'h0000FFFF;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_id", W'(rsp_id), W'(k % 2));
        end

        // Backpressure with both requesting, then release.
        rsp_ready = 1'b0;
        saved = rsp_data;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_data", rsp_data, saved);
            chk("stall_id", W'(rsp_id), 1);
        end
        rsp_ready = 1'b1;
        step();
        chk("release_id", W'(rsp_id), 0);
        chk("release_data", rsp_data, 32'h12345678);

        // Drain with no refill.
        v0 = 1'b0; v1 = 1'b0;
        saved = rsp_data;
        step();
        chk("drain_valid", W'(rsp_valid), 0);
        chk("drain_data", rsp_data, saved);
        step();

        // Reset while stalled; requests held during reset must not be granted.
        v1 = 1'b1; op1 = 2'b11;
        step();
        rsp_ready = 1'b0;
        step();
        rst = 1'b1; v0 = 1'b1; rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", W'(rsp_valid), 0);
        chk("rst_mid_data", rsp_data, '0);
        step();
        chk("post_rst_id", W'(rsp_id), 0);
        step();
        chk("post_rst_id2", W'(rsp_id), 1);
        v0 = 1'b0; v1 = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
